// File: rtl/mcml_result_drain.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mcml_result_drain
//
// Walks the mcml absorption result memory once a simulation has finished.
// Each result word is captured after the core's read latency, offered on a
// valid/ready stream, and folded into a running word count and a 32-bit
// rotate-XOR signature. The first word is read without any inc_result pulse;
// every further word is fetched with exactly one inc_result pulse.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   start            one-cycle request to arm a drain run (IDLE/DONE only)
//   calc_in_progress high while the mcml core simulates; stalls ARM, aborts
//                    an active drain
//   result           current result word from the core
//   inc_result       one-cycle pulse advancing the core's result pointer
//   out_valid        out_data holds a captured word
//   out_ready        downstream accepts out_data when high with out_valid
//   out_data         captured result word
//   busy             run in progress (any state except IDLE and DONE)
//   done             all NUM_WORDS words accepted
//   abort_err        sticky: calc_in_progress rose during a drain
//   word_count       words accepted this run
//   signature        rotate-left-by-one then XOR digest of accepted words
// ---------------------------------------------------------------------------
module mcml_result_drain #(
    parameter int NUM_WORDS = 8192,
    parameter int CNT_W     = 14,
    parameter int READ_LAT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             calc_in_progress,
    input  logic [31:0]      result,
    output logic             inc_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic             abort_err,
    output logic [CNT_W-1:0] word_count,
    output logic [31:0]      signature
);

    localparam logic [2:0]       SETTLE_LOAD = 3'(READ_LAT);
    localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_PRESENT,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       settle_q, settle_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      sig_q, sig_d;
    logic             abort_q, abort_d;
    logic             inc_q, inc_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and next-register values
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        data_d   = data_q;
        count_d  = count_q;
        sig_d    = sig_q;
        abort_d  = abort_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d = '0;
                    sig_d   = '0;
                    abort_d = 1'b0;
                    state_d = S_ARM;
                end
            end

            S_ARM: begin
                if (!calc_in_progress) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (calc_in_progress) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    settle_d = settle_q - 3'd1;
                    // Counter expires on this edge: result now reflects the
                    // word addressed by the most recent pointer move.
                    if (settle_q <= 3'd1) begin
                        settle_d = 3'd0;
                        data_d   = result;
                        state_d  = S_PRESENT;
                    end
                end
            end

            S_PRESENT: begin
                // Abort wins over a same-cycle handshake.
                if (calc_in_progress) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    count_d = count_q + CNT_W'(1);
                    sig_d   = {sig_q[30:0], sig_q[31]} ^ data_q;
                    // No pointer advance after the final word.
                    if (count_q + CNT_W'(1) == LAST_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADVANCE;
                    end
                end
            end

            S_ADVANCE: begin
                if (calc_in_progress) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    settle_d = SETTLE_LOAD;
                    state_d  = S_SETTLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they are glitch-free
        // and line up exactly with the state they describe.
        inc_d  = (state_d == S_ADVANCE);
        vld_d  = (state_d == S_PRESENT);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            settle_q <= 3'd0;
            data_q   <= '0;
            count_q  <= '0;
            sig_q    <= '0;
            abort_q  <= 1'b0;
            inc_q    <= 1'b0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            data_q   <= data_d;
            count_q  <= count_d;
            sig_q    <= sig_d;
            abort_q  <= abort_d;
            inc_q    <= inc_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inc_result = inc_q;
    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign abort_err  = abort_q;
    assign word_count = count_q;
    assign signature  = sig_q;

endmodule
